// File: rtl/seg_pkg.sv
// Shared types and constants for the serial 7-segment display driver.
package seg_pkg;

  localparam int SEG_DIGITS         = 8;
  localparam int SEG_BITS_PER_DIGIT = 8;
  localparam int SEG_NBITS          = SEG_DIGITS * SEG_BITS_PER_DIGIT;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } seg_state_e;

endpackage

// File: rtl/seg_clk_div.sv
// Half-period timer: down-counter that ticks on the last cycle of each
// DIV-cycle phase; restart reloads it so the first phase is always full length.
module seg_clk_div
  import seg_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = $clog2(DIV + 1);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || (cnt == '0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/seg_serial_driver.sv
// Shifts a segment image MSB first into cascaded 74HC595-style registers, then latches.
// Optional SEG_AUTO_REFRESH_EN: send a frame automatically whenever seg_txt changes.
//
// state    | meaning
// IDLE     | waiting for start (or a changed image when auto-refresh is built)
// SHIFT_LO | seg_clk low, seg_dout presenting the current MSB
// SHIFT_HI | seg_clk high, registers sample seg_dout
// LATCH    | seg_latch high, storage registers update
module seg_serial_driver
  import seg_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int NBITS = SEG_NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NBITS-1:0] seg_txt,
  output logic             seg_clk,
  output logic             seg_dout,
  output logic             seg_latch,
  output logic             busy,
  output logic             done
);

  localparam int            BW       = $clog2(NBITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

  seg_state_e       state, state_next;
  logic [NBITS-1:0] shreg, shreg_next;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic             tick;
  logic             start_int;
  logic             seg_clk_d, seg_dout_d, seg_latch_d, busy_d, done_d;

`ifdef SEG_AUTO_REFRESH_EN
  logic [NBITS-1:0] last_txt;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_txt <= '0;
    end else if ((state == IDLE) && start_int) begin
      last_txt <= seg_txt;
    end
  end

  assign start_int = start || (seg_txt != last_txt);
`else
  assign start_int = start;
`endif

  seg_clk_div #(.DIV(DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .restart (state == IDLE),
    .tick    (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      seg_clk   <= 1'b0;
      seg_dout  <= 1'b0;
      seg_latch <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      bit_cnt   <= bit_cnt_next;
      seg_clk   <= seg_clk_d;
      seg_dout  <= seg_dout_d;
      seg_latch <= seg_latch_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    case (state)
      IDLE: begin
        if (start_int) begin
          state_next   = SHIFT_LO;
          shreg_next   = seg_txt;
          bit_cnt_next = '0;
        end
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          shreg_next   = {shreg[NBITS-2:0], 1'b0};
          bit_cnt_next = bit_cnt + 1'b1;
          state_next   = (bit_cnt == LAST_BIT) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    seg_clk_d   = (state_next == SHIFT_HI);
    seg_latch_d = (state_next == LATCH);
    busy_d      = (state_next != IDLE);
    done_d      = (state == LATCH) && tick;
    seg_dout_d  = seg_dout;
    if ((state_next == SHIFT_LO) && (state != SHIFT_LO)) begin
      seg_dout_d = shreg_next[NBITS-1];
    end
  end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Self-checking bench for seg_serial_driver: random frames checked against a frame-level model.
module tb_seg_serial_driver;

  localparam int DIV   = 2;
  localparam int NBITS = 64;
  localparam int FRAME_CYCLES = (2 * NBITS + 1) * DIV + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [NBITS-1:0] seg_txt = '0;
  logic             seg_clk, seg_dout, seg_latch, busy, done;

  seg_serial_driver #(.DIV(DIV), .NBITS(NBITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seg_txt   (seg_txt),
    .seg_clk   (seg_clk),
    .seg_dout  (seg_dout),
    .seg_latch (seg_latch),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt++;

  // Pin monitor: what a chain of 74HC595s would see.
  logic bits_q[$];
  int   rises = 0, latch_cyc = 0, done_cnt = 0, done_edge = 0;
  int   bad_busy = 0, clk_in_done = 0;
  logic prev_clk = 1'b0;

  always @(negedge clk) begin
    if (seg_clk === 1'b1 && prev_clk === 1'b0) begin
      rises++;
      bits_q.push_back(seg_dout);
    end
    prev_clk = seg_clk;
    if (seg_latch === 1'b1) latch_cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_edge = ecnt;
      if (busy !== 1'b0) bad_busy++;
      if (seg_clk !== 1'b0) clk_in_done++;
    end
  end

  int n_checks = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [63:0] frame_at(input int base);
    logic [63:0] v = '0;
    for (int i = 0; i < 64; i++) begin
      v = {v[62:0], (base + i < bits_q.size()) ? bits_q[base + i] : 1'bx};
    end
    return v;
  endfunction

  task automatic send(input logic [63:0] val, output int acc);
    seg_txt = val;
    start   = 1'b1;
    acc     = ecnt + 1;
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n = 0;
    while (done_cnt == base && n < budget) begin
      step();
      n++;
    end
    check("done_timeout", 64'(done_cnt > base), 64'd1);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int acc, r0, l0, d0, first_done;
    logic [63:0] va, vb;

    // Reset with start held high
    rst = 1'b1;
    start = 1'b1;
    repeat (3) begin
      step();
      check("rst_outputs", 64'({seg_clk, seg_dout, seg_latch, busy, done}), 64'd0);
    end
    check("rst_no_edges", 64'(rises), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    step();

`ifdef SEG_AUTO_REFRESH_EN
    repeat (20) step();
    check("auto_idle_zero", 64'(done_cnt), 64'd0);
    va = rnd64() | 64'h1;
    r0 = rises;
    seg_txt = va;
    acc = ecnt + 1;
    step();
    wait_done(0, 400);
    check("auto_frame", frame_at(r0), va);
    check("auto_latency", 64'(done_edge - acc + 1), 64'(FRAME_CYCLES));
    repeat (1000) step();
    check("auto_one_frame", 64'(done_cnt), 64'd1);
    check("auto_rises", 64'(rises - r0), 64'd64);
    r0 = rises;
    send(va, acc);
    wait_done(1, 400);
    check("auto_ext_start", frame_at(r0), va);
`else
    // Single frame with the reference image
    va = 64'hC0F9A4B0_99929282;
    r0 = rises; l0 = latch_cyc; d0 = done_cnt;
    send(va, acc);
    wait_done(d0, 400);
    check("single_frame", frame_at(r0), va);
    check("single_rises", 64'(rises - r0), 64'd64);
    check("single_latch", 64'(latch_cyc - l0), 64'd2);
    check("single_latency", 64'(done_edge - acc + 1), 64'(FRAME_CYCLES));
    step();
    check("single_idle", 64'({busy, done}), 64'd0);

    // Image changes without start send nothing
    r0 = rises;
    repeat (40) begin
      seg_txt = rnd64();
      step();
    end
    check("no_start_no_frame", 64'(rises - r0), 64'd0);

    // Busy protection: extra starts and image changes mid-frame
    for (int it = 0; it < 3; it++) begin
      va = rnd64();
      r0 = rises; d0 = done_cnt;
      send(va, acc);
      for (int k = 1; k <= 120; k++) begin
        start = (k == 10 || k == 100);
        if (k == 60) seg_txt = rnd64();
        step();
      end
      start = 1'b0;
      wait_done(d0, 400);
      check("busy_frame", frame_at(r0), va);
      repeat (300) step();
      check("busy_one_done", 64'(done_cnt - d0), 64'd1);
      check("busy_rises", 64'(rises - r0), 64'd64);
    end

    // Back-to-back frames with start held high
    va = rnd64();
    vb = rnd64();
    r0 = rises; d0 = done_cnt;
    seg_txt = va;
    start = 1'b1;
    step();
    seg_txt = vb;
    wait_done(d0, 400);
    first_done = done_edge;
    step();
    check("b2b_restart", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done(d0 + 1, 400);
    check("b2b_frame_a", frame_at(r0), va);
    check("b2b_frame_b", frame_at(r0 + 64), vb);
    check("b2b_rises", 64'(rises - r0), 64'd128);
    check("b2b_gap", 64'(done_edge - first_done), 64'(FRAME_CYCLES));

    // Abort mid-frame
    l0 = latch_cyc; d0 = done_cnt;
    send(rnd64(), acc);
    repeat (49) step();
    rst = 1'b1;
    step();
    check("abort_outputs", 64'({seg_clk, seg_dout, seg_latch, busy, done}), 64'd0);
    rst = 1'b0;
    repeat (300) step();
    check("abort_no_latch", 64'(latch_cyc - l0), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    va = rnd64();
    r0 = rises;
    send(va, acc);
    wait_done(d0, 400);
    check("abort_next_frame", frame_at(r0), va);
    check("abort_next_rises", 64'(rises - r0), 64'd64);
`endif

    check("done_while_busy", 64'(bad_busy), 64'd0);
    check("clk_high_in_done", 64'(clk_in_done), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
